and_reduce_pipe: RTL and testbench
==================================

Name: and_reduce_pipe

Overview:
- Parametrised, pipelined, multi-lane AND/NAND reduction cell. It is the sequential successor to the 2-input combinational AND gate in the gp9t3v3 library.
- Each lane reduces a WIDTH-bit operand to one bit through a tree of FANIN-input AND stages, with one register stage per tree level.
- Data moves through the pipeline under a valid/ready handshake. Empty stages collapse, so bubbles do not cost throughput.
- Used in wide compare/match and all-ones detection where a single-level AND would miss timing.

Parameters:
- WIDTH, 16, operand bits per lane; must be >= 2.
- LANES, 2, number of independent reduction lanes.
- FANIN, 4, AND inputs per tree node; must be >= 2.
- STAGES, derived (not overridable), ceil(log_FANIN(WIDTH)), minimum 1; equals the pipeline depth.

Ports:
- CLK  input  1  rising-edge clock.
- RN  input  1  asynchronous active-low reset.
- A  input  LANES*WIDTH  operands; lane i occupies A[i*WIDTH +: WIDTH].
- M  input  WIDTH  bit-enable mask shared by all lanes; M[j]=0 excludes bit j by forcing it to 1.
- INV  input  1  0 selects AND, 1 selects NAND (final result inverted).
- IN_VALID  input  1  operand valid.
- IN_READY  output  1  pipeline can accept an operand this cycle.
- Y  output  LANES  reduction result, one bit per lane.
- OUT_VALID  output  1  Y is valid.
- OUT_READY  input  1  downstream accepts Y.

Behaviour:
- Reset, asynchronous on RN low:
  - All stage valid bits clear to 0; all data and INV pipeline registers clear to 0.
  - Y = 0 and OUT_VALID = 0 immediately, without waiting for a clock edge.
  - IN_READY = 1 while the pipeline is empty.
- Release: deassertion of RN is synchronised by the integrator. The block's first accept occurs on the first CLK edge after RN is high.
- Input conditioning, per lane: operand x = A_lane | ~M. The upper level is padded with 1s (the AND identity) when WIDTH is not a power of FANIN.
- Tree structure:
  - Stage k (0..STAGES-1) registers the FANIN-way AND of the previous level's outputs.
  - Stage STAGES-1 holds one bit per lane.
  - INV is captured at stage 0 and travels with the data. It is applied at the last stage: Y = last ^ inv_pipe.
  - A change on INV never affects operands already in flight.
- Handshake:
  - Accept occurs when IN_VALID & IN_READY on a rising CLK. Transfer out occurs when OUT_VALID & OUT_READY.
  - Per-stage ready: rdy_k = !v_k | rdy_(k+1), with rdy_STAGES = OUT_READY. IN_READY = rdy_0. This is a combinational path from OUT_READY to IN_READY and is documented for the integrator.
  - Stage k loads when rdy_k is high. Its valid bit becomes the upstream valid (IN_VALID for k=0). Its data is loaded only when the upstream valid is 1.
  - OUT_VALID = v_(STAGES-1). Y is taken directly from the last-stage register.
- Latency and throughput:
  - Without stall, an operand accepted at edge n gives OUT_VALID at edge n+STAGES-1, i.e. visible during cycle n+STAGES.
  - Throughput is 1 operand per cycle.
- Stall: while OUT_VALID=1 and OUT_READY=0, Y and OUT_VALID hold stable. Upstream stages keep filling until every stage is valid; IN_READY then drops.
- Bubble collapse: an empty stage loads even when the downstream stage is stalled.
- Ordering: results appear strictly in accept order. There is no loss and no duplication.
- Simultaneous events: on the same edge a stage may load a new operand and hand its old one downstream.
- IN_VALID may drop without accept; a dropped operand is never captured.
- Reset mid-operation: all in-flight operands are discarded and no partial output is emitted.
- Y is undefined-free: it is always driven from registers, never X after reset.

Test Plan:
- Reset: stream 3 operands, pulse RN low mid-stream without a clock edge -> OUT_VALID=0 and Y=2'b00 at once. After release, IN_READY=1 and no stale result appears.
- Basic AND (WIDTH=16, FANIN=4, LANES=2, STAGES=2), with M=16'hFFFF, INV=0, OUT_READY=1:
  - Stimulus: lane0=16'hFFFF, lane1=16'hFFFE, accepted at edge 0.
  - Response: OUT_VALID high after edge 1 with Y=2'b01.
- Mask and NAND:
  - lane1=16'hFFFE with M=16'hFFFE -> Y[1]=1.
  - Same operand with INV=1 -> Y=2'b00.
  - Toggle INV while that operand is in flight -> its result is unaffected.
- Backpressure:
  - Stimulus: OUT_READY=0, offer 4 back-to-back operands with distinct results (01, 10, 11, 00).
  - Response: exactly 2 are accepted and IN_READY=0 afterwards; Y holds 01 for 5 cycles.
  - Then raise OUT_READY: Y sequence is 01, 10, 11, 00 with no gaps after the first release.
- Bubble collapse:
  - Stimulus: single operand, OUT_READY=0, then a second operand 3 cycles later.
  - Response: the second operand is accepted (IN_READY=1) and fills stage 0; IN_READY then drops.
- Non-power width (WIDTH=5, FANIN=4, STAGES=2):
  - A=5'h1F -> Y=1.
  - A=5'h0F -> Y=0.
  - A=5'h0F with M=5'h0F -> Y=1. This confirms 1-padding and masking.

Source files
------------

// File: rtl/and_reduce_pipe.sv
// and_reduce_pipe: multi-lane AND/NAND reduction tree, one register per tree level, valid/ready handshake.
// IN_READY depends combinationally on OUT_READY through the per-stage ready chain.
module and_reduce_pipe #(
  parameter int WIDTH = 16,
  parameter int LANES = 2,
  parameter int FANIN = 4
) (
  input  logic                   CLK,
  input  logic                   RN,
  input  logic [LANES*WIDTH-1:0] A,
  input  logic [WIDTH-1:0]       M,
  input  logic                   INV,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  output logic [LANES-1:0]       Y,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY
);
  function automatic int depth(int w, int f);
    int s = 0;
    int p = 1;
    while (p < w) begin
      p = p * f;
      s++;
    end
    return s < 1 ? 1 : s;
  endfunction

  function automatic int pw(int f, int e);
    int p = 1;
    for (int i = 0; i < e; i++) p = p * f;
    return p;
  endfunction

  localparam int STAGES = depth(WIDTH, FANIN);
  localparam int TOP    = pw(FANIN, STAGES);

  logic [LANES*TOP-1:0] x;
  logic [STAGES-1:0]    v, inv_p;
  logic [STAGES:0]      rdy;

  // masked-off bits and the padding above WIDTH are forced to the AND identity
  always_comb begin
    x = '1;
    for (int l = 0; l < LANES; l++)
      for (int j = 0; j < WIDTH; j++)
        x[l*TOP+j] = A[l*WIDTH+j] | ~M[j];
  end

  assign rdy[STAGES] = OUT_READY;

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stg
    localparam int IW = pw(FANIN, STAGES - k);
    localparam int OW = IW / FANIN;
    logic [LANES*IW-1:0] src;
    logic [LANES*OW-1:0] nxt, d;
    logic up, up_inv, vs, is;
    if (k == 0) begin : g_first
      assign src    = x;
      assign up     = IN_VALID;
      assign up_inv = INV;
    end else begin : g_next
      assign src    = g_stg[k-1].d;
      assign up     = v[k-1];
      assign up_inv = inv_p[k-1];
    end
    always_comb begin
      nxt = '0;
      for (int i = 0; i < LANES*OW; i++) nxt[i] = &src[i*FANIN +: FANIN];
    end
    // an empty stage loads even while its successor is stalled
    assign rdy[k]   = !vs | rdy[k+1];
    assign v[k]     = vs;
    assign inv_p[k] = is;
    always_ff @(posedge CLK or negedge RN)
      if (!RN) begin
        vs <= 1'b0;
        is <= 1'b0;
        d  <= '0;
      end else if (rdy[k]) begin
        vs <= up;
        if (up) begin
          d  <= nxt;
          is <= up_inv;
        end
      end
  end

  assign IN_READY  = rdy[0];
  assign OUT_VALID = v[STAGES-1];
  assign Y         = g_stg[STAGES-1].d ^ {LANES{inv_p[STAGES-1]}};
endmodule

// File: tb/tb_and_reduce_pipe.sv
// tb_and_reduce_pipe: directed checks of reset, AND/NAND/mask, backpressure, bubble collapse and non-power widths.
module tb_and_reduce_pipe;
  logic        clk = 1'b0;
  logic        rn = 1'b0;
  logic [31:0] a = '0;
  logic [15:0] m = 16'hFFFF;
  logic        inv = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid;
  logic [1:0]  y;
  logic [4:0]  a5 = '0, m5 = 5'h1F;
  logic        in_valid5 = 1'b0, in_ready5, out_valid5;
  logic [0:0]  y5;
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  and_reduce_pipe dut (
    .CLK(clk), .RN(rn), .A(a), .M(m), .INV(inv), .IN_VALID(in_valid), .IN_READY(in_ready),
    .Y(y), .OUT_VALID(out_valid), .OUT_READY(out_ready)
  );

  and_reduce_pipe #(.WIDTH(5), .LANES(1), .FANIN(4)) dut5 (
    .CLK(clk), .RN(rn), .A(a5), .M(m5), .INV(1'b0), .IN_VALID(in_valid5), .IN_READY(in_ready5),
    .Y(y5), .OUT_VALID(out_valid5), .OUT_READY(1'b1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick;
    tick;
    rn = 1'b1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ov: got %b expected 0", out_valid); end
    n_chk++; if (y !== 2'b00) begin n_fail++; $display("FAIL reset_y: got %b expected 00", y); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ir: got %b expected 1", in_ready); end
    a = 32'hFFFF_FFFF;
    in_valid = 1'b1;
    tick;
    tick;
    tick;
    n_chk++; if (out_valid !== 1'b1 || y !== 2'b11) begin n_fail++; $display("FAIL stream_pre: got ov=%b y=%b expected ov=1 y=11", out_valid, y); end
    #1 rn = 1'b0;
    #1;
    n_chk++; if (out_valid !== 1'b0 || y !== 2'b00) begin n_fail++; $display("FAIL async_rst: got ov=%b y=%b expected ov=0 y=00", out_valid, y); end
    in_valid = 1'b0;
    #1 rn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick;
      n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst%0d: got ov=%b ir=%b expected ov=0 ir=1", c, out_valid, in_ready); end
    end
  endtask

  task automatic test_basic_and;
    a = {16'hFFFE, 16'hFFFF};
    m = 16'hFFFF;
    inv = 1'b0;
    in_valid = 1'b1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ir: got %b expected 1", in_ready); end
    tick;
    in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_lat: got ov=%b expected 0", out_valid); end
    tick;
    n_chk++; if (out_valid !== 1'b1 || y !== 2'b01) begin n_fail++; $display("FAIL basic_y: got ov=%b y=%b expected ov=1 y=01", out_valid, y); end
    tick;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got ov=%b expected 0", out_valid); end
  endtask

  task automatic test_mask_nand;
    a = {16'hFFFE, 16'hFFFF};
    m = 16'hFFFE;
    inv = 1'b0;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    n_chk++; if (out_valid !== 1'b1 || y !== 2'b11) begin n_fail++; $display("FAIL mask_y: got ov=%b y=%b expected ov=1 y=11", out_valid, y); end
    inv = 1'b1;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    n_chk++; if (out_valid !== 1'b1 || y !== 2'b00) begin n_fail++; $display("FAIL nand_y: got ov=%b y=%b expected ov=1 y=00", out_valid, y); end
    inv = 1'b0;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    inv = 1'b1;
    tick;
    n_chk++; if (out_valid !== 1'b1 || y !== 2'b11) begin n_fail++; $display("FAIL inv_inflight: got ov=%b y=%b expected ov=1 y=11", out_valid, y); end
    inv = 1'b0;
    m = 16'hFFFF;
    tick;
  endtask

  task automatic test_backpressure;
    logic [31:0] ops [4];
    logic [1:0]  exp_y [4];
    int idx;
    logic acc;
    ops[0] = {16'hFFFE, 16'hFFFF}; exp_y[0] = 2'b01;
    ops[1] = {16'hFFFF, 16'hFFFE}; exp_y[1] = 2'b10;
    ops[2] = {16'hFFFF, 16'hFFFF}; exp_y[2] = 2'b11;
    ops[3] = 32'h0000_0000;        exp_y[3] = 2'b00;
    idx = 0;
    out_ready = 1'b0;
    a = ops[0];
    in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      acc = in_ready & in_valid;
      tick;
      if (acc) idx++;
      if (idx < 4) a = ops[idx];
      if (c >= 1) begin
        n_chk++; if (out_valid !== 1'b1 || y !== 2'b01) begin n_fail++; $display("FAIL bp_hold%0d: got ov=%b y=%b expected ov=1 y=01", c, out_valid, y); end
      end
    end
    n_chk++; if (idx !== 2) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 2", idx); end
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ir: got %b expected 0", in_ready); end
    out_ready = 1'b1;
    #1;
    for (int r = 0; r < 4; r++) begin
      n_chk++; if (out_valid !== 1'b1 || y !== exp_y[r]) begin n_fail++; $display("FAIL bp_seq%0d: got ov=%b y=%b expected ov=1 y=%b", r, out_valid, y, exp_y[r]); end
      acc = in_ready & in_valid;
      tick;
      if (acc) idx++;
      if (idx < 4) a = ops[idx];
      else in_valid = 1'b0;
    end
    n_chk++; if (out_valid !== 1'b0 || idx !== 4) begin n_fail++; $display("FAIL bp_drain: got ov=%b idx=%0d expected ov=0 idx=4", out_valid, idx); end
  endtask

  task automatic test_bubble_collapse;
    out_ready = 1'b0;
    a = {16'hFFFE, 16'hFFFF};
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bub_ir: got %b expected 1", in_ready); end
    a = {16'hFFFF, 16'hFFFE};
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    n_chk++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || y !== 2'b01) begin n_fail++; $display("FAIL bub_full: got ir=%b ov=%b y=%b expected ir=0 ov=1 y=01", in_ready, out_valid, y); end
    out_ready = 1'b1;
    tick;
    n_chk++; if (out_valid !== 1'b1 || y !== 2'b10) begin n_fail++; $display("FAIL bub_second: got ov=%b y=%b expected ov=1 y=10", out_valid, y); end
    tick;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bub_drain: got ov=%b expected 0", out_valid); end
  endtask

  task automatic test_non_power;
    a5 = 5'h1F; m5 = 5'h1F; in_valid5 = 1'b1;
    tick;
    a5 = 5'h0F;
    tick;
    n_chk++; if (out_valid5 !== 1'b1 || y5 !== 1'b1) begin n_fail++; $display("FAIL np_1f: got ov=%b y=%b expected ov=1 y=1", out_valid5, y5); end
    m5 = 5'h0F;
    tick;
    in_valid5 = 1'b0;
    n_chk++; if (out_valid5 !== 1'b1 || y5 !== 1'b0) begin n_fail++; $display("FAIL np_0f: got ov=%b y=%b expected ov=1 y=0", out_valid5, y5); end
    tick;
    n_chk++; if (out_valid5 !== 1'b1 || y5 !== 1'b1) begin n_fail++; $display("FAIL np_mask: got ov=%b y=%b expected ov=1 y=1", out_valid5, y5); end
    tick;
    n_chk++; if (out_valid5 !== 1'b0) begin n_fail++; $display("FAIL np_drain: got ov=%b expected 0", out_valid5); end
  endtask

  initial begin
    test_reset;
    test_basic_and;
    test_mask_nand;
    test_backpressure;
    test_bubble_collapse;
    test_non_power;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
